// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration chain loader.
// Contents:
//   state_t      - loader FSM states
//   phase_t      - low/high half of one serial bit
//   RST_CYCLES   - length of the chain reset sequence
//   rst_clk_next - config_clk value for the next cycle of the reset sequence
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        FETCH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    localparam int RST_CYCLES = 4;
    localparam int RST_CNT_W  = $clog2(RST_CYCLES);

    // The reset sequence drives config_clk 0,1,0,1. The counter holds the
    // index of the current reset cycle, so the next cycle's level is the
    // inverse of the current index's LSB.
    function automatic logic rst_clk_next(input logic [RST_CNT_W-1:0] cnt);
        return ~cnt[0];
    endfunction

endpackage

// File: rtl/cfg_bit_serializer.sv
// Serialiser for the configuration chain.
// Holds the word shift register, the count of bits left in the current word,
// the low/high bit phase and the registered config_clk / config_in pins.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   load, word,     - latch a new word and the number of its bits to shift
//   bits_load
//   rst_drive,      - during the chain reset sequence, drive config_clk to
//   rst_clk           rst_clk next cycle
//   shift_en        - advance the low/high bit phase (SHIFT state)
//   config_clk,     - registered chain clock and data
//   config_in
//   phase           - current bit phase
//   last_bit        - the bit being shifted is the last one of this word
module cfg_bit_serializer
    import cfg_loader_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BIT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic [BIT_W-1:0]  bits_load,
    input  logic              rst_drive,
    input  logic              rst_clk,
    input  logic              shift_en,
    output logic              config_clk,
    output logic              config_in,
    output phase_t            phase,
    output logic              last_bit
);

    logic [WORD_W-1:0] sr_r;
    logic [WORD_W-1:0] sr_next_s;
    logic [BIT_W-1:0]  bits_in_word_r;
    phase_t            phase_r;
    logic              config_clk_r;
    logic              config_in_r;

    assign sr_next_s  = sr_r >> 1;
    assign last_bit   = (bits_in_word_r == BIT_W'(1));
    assign config_clk = config_clk_r;
    assign config_in  = config_in_r;
    assign phase      = phase_r;

    // Shift register, bit phase and the chain pin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r           <= '0;
            bits_in_word_r <= '0;
            phase_r        <= PH_LOW;
            config_clk_r   <= 1'b0;
            config_in_r    <= 1'b0;
        end else if (load) begin
            // First bit goes out immediately so it is stable a full low phase.
            sr_r           <= word;
            bits_in_word_r <= bits_load;
            phase_r        <= PH_LOW;
            config_clk_r   <= 1'b0;
            config_in_r    <= word[0];
        end else if (rst_drive) begin
            phase_r        <= PH_LOW;
            config_clk_r   <= rst_clk;
            config_in_r    <= 1'b0;
        end else if (shift_en) begin
            case (phase_r)
                PH_LOW: begin
                    config_clk_r <= 1'b1;
                    phase_r      <= PH_HIGH;
                end
                PH_HIGH: begin
                    config_clk_r   <= 1'b0;
                    phase_r        <= PH_LOW;
                    sr_r           <= sr_next_s;
                    bits_in_word_r <= bits_in_word_r - BIT_W'(1);
                    // Unused upper bits of the final word never reach the pin.
                    config_in_r    <= last_bit ? 1'b0 : sr_next_s[0];
                end
                default: begin
                    config_clk_r <= 1'b0;
                    phase_r      <= PH_LOW;
                end
            endcase
        end else begin
            phase_r      <= PH_LOW;
            config_clk_r <= 1'b0;
            config_in_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Bitstream loader for a serial CGRA configuration chain.
// Accepts configuration words on a valid/ready stream, resets the chain,
// then shifts exactly CHAIN_LEN bits (bit 0 of each word first) while
// checking that the chain tail stays zero.
// Ports:
//   clk, reset               - system clock, synchronous active-high reset
//   start                    - begin a load (honoured only when idle)
//   word_data/valid/ready    - configuration word stream
//   busy, done, err          - load status; err is sticky until next start
//   config_clk/reset/in      - registered chain drive pins
//   config_out               - chain tail, expected zero throughout a load
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 14,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              config_clk,
    output logic              config_reset,
    output logic              config_in,
    input  logic              config_out
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);

    state_t               state_r;
    logic [CNT_W-1:0]     remaining_r;
    logic [RST_CNT_W-1:0] rst_cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic                 word_ready_r;
    logic                 config_reset_r;

    logic                 load_s;
    logic                 shift_en_s;
    logic                 bit_done_s;
    logic                 rst_drive_s;
    logic                 rst_clk_s;
    logic [BIT_W-1:0]     bits_load_s;
    phase_t               phase_s;
    logic                 last_bit_s;

    assign word_ready   = word_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign config_reset = config_reset_r;

    // Control strobes for the serialiser derived from the current state.
    always_comb begin
        load_s      = (state_r == FETCH) && word_valid && word_ready_r;
        shift_en_s  = (state_r == SHIFT);
        bit_done_s  = shift_en_s && (phase_s == PH_HIGH);
        rst_drive_s = 1'b0;
        rst_clk_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // First reset cycle starts with config_clk low.
                rst_drive_s = start;
                rst_clk_s   = 1'b0;
            end
            RST: begin
                rst_drive_s = (rst_cnt_r != RST_CNT_W'(RST_CYCLES - 1));
                rst_clk_s   = rst_clk_next(rst_cnt_r);
            end
            default: begin
                rst_drive_s = 1'b0;
                rst_clk_s   = 1'b0;
            end
        endcase
        if (32'(remaining_r) < 32'(WORD_W)) begin
            bits_load_s = BIT_W'(remaining_r);
        end else begin
            bits_load_s = BIT_W'(WORD_W);
        end
    end

    // Loader FSM, bit budget, stream handshake and integrity flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            remaining_r    <= '0;
            rst_cnt_r      <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
            word_ready_r   <= 1'b0;
            config_reset_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r         <= 1'b0;
                    word_ready_r   <= 1'b0;
                    if (start) begin
                        state_r        <= RST;
                        busy_r         <= 1'b1;
                        err_r          <= 1'b0;
                        remaining_r    <= CNT_W'(CHAIN_LEN);
                        rst_cnt_r      <= '0;
                        config_reset_r <= 1'b1;
                    end else begin
                        state_r        <= IDLE;
                        busy_r         <= 1'b0;
                        config_reset_r <= 1'b0;
                    end
                end
                RST: begin
                    if (rst_cnt_r == RST_CNT_W'(RST_CYCLES - 1)) begin
                        state_r        <= FETCH;
                        rst_cnt_r      <= '0;
                        config_reset_r <= 1'b0;
                        word_ready_r   <= 1'b1;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RST_CNT_W'(1);
                    end
                end
                FETCH: begin
                    if (load_s) begin
                        state_r      <= SHIFT;
                        word_ready_r <= 1'b0;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                SHIFT: begin
                    // The chain was just reset, so its tail must read zero.
                    if ((phase_s == PH_LOW) && config_out) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= err_r;
                    end
                    if (bit_done_s) begin
                        remaining_r <= remaining_r - CNT_W'(1);
                        if (remaining_r == CNT_W'(1)) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else if (last_bit_s) begin
                            state_r      <= FETCH;
                            word_ready_r <= 1'b1;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r        <= IDLE;
                    busy_r         <= 1'b0;
                    done_r         <= 1'b0;
                    word_ready_r   <= 1'b0;
                    config_reset_r <= 1'b0;
                end
            endcase
        end
    end

    cfg_bit_serializer #(
        .WORD_W (WORD_W),
        .BIT_W  (BIT_W)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .word       (word_data),
        .bits_load  (bits_load_s),
        .rst_drive  (rst_drive_s),
        .rst_clk    (rst_clk_s),
        .shift_en   (shift_en_s),
        .config_clk (config_clk),
        .config_in  (config_in),
        .phase      (phase_s),
        .last_bit   (last_bit_s)
    );

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: a 14-bit chain instance driven
// with table-checked directed loads, and a 40-bit chain instance for the
// multi-word / stall case. Behavioural chain models sit on both instances.
module tb_cfg_chain_loader;

    typedef struct packed {
        logic busy;
        logic ready;
        logic creset;
        logic cclk;
        logic cin;
        logic done;
        logic err;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start14, word_valid14, word_ready14, busy14, done14, err14;
    logic        cclk14, creset14, cin14, cout14;
    logic [31:0] word_data14;

    logic        start40, word_valid40, word_ready40, busy40, done40, err40;
    logic        cclk40, creset40, cin40, cout40;
    logic [31:0] word_data40;

    cfg_chain_loader #(.CHAIN_LEN(14), .WORD_W(32)) dut (
        .clk(clk), .reset(reset), .start(start14), .word_data(word_data14),
        .word_valid(word_valid14), .word_ready(word_ready14), .busy(busy14),
        .done(done14), .err(err14), .config_clk(cclk14),
        .config_reset(creset14), .config_in(cin14), .config_out(cout14)
    );

    cfg_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut40 (
        .clk(clk), .reset(reset), .start(start40), .word_data(word_data40),
        .word_valid(word_valid40), .word_ready(word_ready40), .busy(busy40),
        .done(done40), .err(err40), .config_clk(cclk40),
        .config_reset(creset40), .config_in(cin40), .config_out(cout40)
    );

    // Behavioural chains: reset on a config_clk edge under config_reset,
    // otherwise shift toward the tail.
    logic        stuck = 1'b0;
    logic [13:0] chain14 = 14'h3FFF;
    logic [39:0] chain40 = '1;

    always @(posedge cclk14) begin
        if (creset14) chain14 <= '0;
        else          chain14 <= {chain14[12:0], cin14};
    end
    always @(posedge cclk40) begin
        if (creset40) chain40 <= '0;
        else          chain40 <= {chain40[38:0], cin40};
    end
    assign cout14 = stuck | chain14[13];
    assign cout40 = chain40[39];

    int consumed14 = 0;
    int consumed40 = 0;
    always @(posedge clk) begin
        if (word_valid14 && word_ready14) consumed14 <= consumed14 + 1;
        if (word_valid40 && word_ready40) consumed40 <= consumed40 + 1;
    end

    int   n_cmp  = 0;
    int   n_fail = 0;
    obs_t rec14 [0:43];
    obs_t rec40 [0:99];
    vec_t tbl   [0:13];

    function automatic obs_t obs14();
        return obs_t'({busy14, word_ready14, creset14, cclk14, cin14, done14, err14});
    endfunction
    function automatic obs_t obs40();
        return obs_t'({busy40, word_ready40, creset40, cclk40, cin40, done40, err40});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One load on the 14-bit instance; start is accepted in cycle 0.
    task automatic run14(input logic [31:0] w, input int reset_at, input bit extra_starts);
        word_data14  = w;
        word_valid14 = 1'b1;
        start14      = 1'b1;
        rec14[0]     = obs14();
        for (int c = 1; c < 44; c++) begin
            @(posedge clk); #1;
            start14  = extra_starts && (c == 10 || c == 20);
            reset    = (c == reset_at);
            rec14[c] = obs14();
        end
        start14 = 1'b0;
        reset   = 1'b0;
    endtask

    function automatic int count_done14();
        int n = 0;
        for (int c = 0; c < 44; c++) n += int'(rec14[c].done);
        return n;
    endfunction

    // Checks for a clean load of word 0x00002A5B on the 14-bit instance.
    task automatic check_basic(input string tag, input int consumed_before);
        logic [31:0] w;
        w = 32'h0000_2A5B;
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("%s_cyc%0d", tag, tbl[i].cyc), 64'(rec14[tbl[i].cyc]), 64'(tbl[i].exp));
        end
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("%s_bit%0d", tag, k),
                64'({rec14[6 + 2 * k].cin, rec14[7 + 2 * k].cin}), 64'({w[k], w[k]}));
        end
        chk({tag, "_chain"},   64'(chain14), 64'(14'h3695));
        chk({tag, "_ndone"},   64'(count_done14()), 64'(1));
        chk({tag, "_words"},   64'(consumed14 - consumed_before), 64'(1));
        chk({tag, "_idle_rdy"}, 64'(rec14[43].ready), 64'(1'b0));
    endtask

    initial begin
        int          c0;
        int          edges;
        int          ones;
        int          idx;
        logic        hold;
        logic [39:0] stream;
        logic [39:0] exp_stream;
        logic [39:0] exp_chain;
        logic [31:0] w0;
        logic [31:0] w1;

        //                    busy rdy crst cclk cin done err
        tbl[0]  = '{1,  7'b1_0_1_0_0_0_0};
        tbl[1]  = '{2,  7'b1_0_1_1_0_0_0};
        tbl[2]  = '{3,  7'b1_0_1_0_0_0_0};
        tbl[3]  = '{4,  7'b1_0_1_1_0_0_0};
        tbl[4]  = '{5,  7'b1_1_0_0_0_0_0};
        tbl[5]  = '{6,  7'b1_0_0_0_1_0_0};
        tbl[6]  = '{7,  7'b1_0_0_1_1_0_0};
        tbl[7]  = '{8,  7'b1_0_0_0_1_0_0};
        tbl[8]  = '{10, 7'b1_0_0_0_0_0_0};
        tbl[9]  = '{11, 7'b1_0_0_1_0_0_0};
        tbl[10] = '{32, 7'b1_0_0_0_1_0_0};
        tbl[11] = '{33, 7'b1_0_0_1_1_0_0};
        tbl[12] = '{34, 7'b1_0_0_0_0_1_0};
        tbl[13] = '{35, 7'b0_0_0_0_0_0_0};

        reset        = 1'b1;
        start14      = 1'b0;
        word_valid14 = 1'b0;
        word_data14  = '0;
        start40      = 1'b0;
        word_valid40 = 1'b0;
        word_data40  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset14", 64'(obs14()), 64'(0));
        chk("reset40", 64'(obs40()), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic load.
        c0 = consumed14;
        run14(32'h0000_2A5B, -1, 1'b0);
        check_basic("basic", c0);

        // Tail stuck at one: err from the first sample, sticky past done.
        stuck = 1'b1;
        run14(32'h0000_2A5B, -1, 1'b0);
        chk("err_cyc6",  64'(rec14[6].err), 64'(1'b0));
        chk("err_cyc7",  64'(rec14[7].err), 64'(1'b1));
        chk("err_done",  64'({rec14[34].done, rec14[34].err}), 64'(2'b11));
        chk("err_after", 64'(rec14[43].err), 64'(1'b1));
        stuck = 1'b0;
        run14(32'h0000_2A5B, -1, 1'b0);
        chk("err_pre_start", 64'(rec14[0].err), 64'(1'b1));
        chk("err_cleared",   64'(rec14[1].err), 64'(1'b0));
        chk("err_clean_end", 64'(rec14[34].err), 64'(1'b0));

        // Reset in cycle 15 of a load (with err already set).
        stuck = 1'b1;
        run14(32'h0000_2A5B, 15, 1'b0);
        chk("rst_err_before", 64'(rec14[15].err), 64'(1'b1));
        chk("rst_outputs",    64'(rec14[16]), 64'(0));
        chk("rst_ndone",      64'(count_done14()), 64'(0));
        stuck = 1'b0;
        c0 = consumed14;
        run14(32'h0000_2A5B, -1, 1'b0);
        check_basic("after_rst", c0);

        // Extra start pulses mid-load are ignored.
        c0 = consumed14;
        run14(32'h0000_2A5B, -1, 1'b1);
        check_basic("restart", c0);

        // Two-word load on the 40-bit chain with a 3-cycle stall.
        w0          = 32'hDEAD_BEEF;
        w1          = 32'hFFFF_FFA5;
        c0          = consumed40;
        word_data40 = w0;
        word_valid40 = 1'b1;
        start40     = 1'b1;
        rec40[0]    = obs40();
        for (int c = 1; c < 100; c++) begin
            @(posedge clk); #1;
            start40 = 1'b0;
            if (c == 6)  word_valid40 = 1'b0;
            if (c == 73) begin
                word_data40  = w1;
                word_valid40 = 1'b1;
            end
            if (c == 74) word_valid40 = 1'b0;
            rec40[c] = obs40();
        end
        hold = 1'b0;
        for (int c = 70; c <= 73; c++) hold |= rec40[c].cclk | ~rec40[c].ready;
        chk("mw_stall_clk_low", 64'(hold), 64'(1'b0));
        edges  = 0;
        ones   = 0;
        idx    = 0;
        stream = '0;
        for (int c = 5; c < 100; c++) begin
            if (rec40[c].cclk && !rec40[c - 1].cclk) begin
                edges++;
                if (idx < 40) stream[idx] = rec40[c].cin;
                idx++;
            end
        end
        for (int c = 0; c < 100; c++) ones += int'(rec40[c].cin);
        exp_stream = {w1[7:0], w0};
        for (int k = 0; k < 40; k++) exp_chain[39 - k] = exp_stream[k];
        chk("mw_edges",  64'(edges), 64'(40));
        chk("mw_stream", 64'(stream), 64'(exp_stream));
        chk("mw_ones",   64'(ones), 64'(2 * $countones(exp_stream)));
        chk("mw_done89", 64'(rec40[89].done), 64'(1'b0));
        chk("mw_done90", 64'({rec40[90].done, rec40[90].busy}), 64'(2'b11));
        chk("mw_busy91", 64'(rec40[91].busy), 64'(1'b0));
        chk("mw_err",    64'(rec40[95].err), 64'(1'b0));
        chk("mw_words",  64'(consumed40 - c0), 64'(2));
        chk("mw_chain",  64'(chain40), 64'(exp_chain));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
